// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: controller states, round count and compact iota constants.
package keccak_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StPermute
    } squeeze_state_e;

    // Bit j of an entry lands on lane bit 2**j - 1 of lane (0,0).
    localparam logic [6:0] RC [24] = '{
        7'h01, 7'h1A, 7'h5E, 7'h70, 7'h1F, 7'h21, 7'h79, 7'h55,
        7'h0E, 7'h0C, 7'h35, 7'h26, 7'h3F, 7'h4F, 7'h5D, 7'h53,
        7'h52, 7'h48, 7'h16, 7'h66, 7'h79, 7'h58, 7'h21, 7'h74
    };

    function automatic int unsigned nr(input int unsigned lw);
        return 12 + 2 * lw;
    endfunction

endpackage

// File: rtl/keccak_round.sv
// One combinational Keccak-p round (theta, rho, pi, chi, iota) on a 25-lane state.
module keccak_round #(
    parameter int unsigned l = 6,
    parameter int unsigned w = 2**l
) (
    input  logic [25*w-1:0] state_i,
    input  logic [l:0]      rc_i,
    output logic [25*w-1:0] state_o
);

    localparam int unsigned RHO [25] = '{
        0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
        41, 45, 15, 21, 8, 18, 2, 61, 56, 14
    };

    function automatic logic [w-1:0] rotl(input logic [w-1:0] v, input int unsigned n);
        if (n == 0) return v;
        return (v << n) | (v >> (w - n));
    endfunction

    logic [w-1:0] a  [25];
    logic [w-1:0] t  [25];
    logic [w-1:0] p  [25];
    logic [w-1:0] ch [25];
    logic [w-1:0] c  [5];
    logic [w-1:0] d  [5];
    logic [w-1:0] rc_lane;

    always_comb begin
        for (int k = 0; k < 25; k++) a[k] = state_i[w*k +: w];
        for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1);
        for (int k = 0; k < 25; k++) t[k] = a[k] ^ d[k%5];
        // Lane (x,y) moves to (y, 2x+3y) after its rho rotation.
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                p[y + 5*((2*x + 3*y) % 5)] = rotl(t[x + 5*y], RHO[x + 5*y] % w);
            end
        end
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                ch[x + 5*y] = p[x + 5*y] ^ (~p[(x+1)%5 + 5*y] & p[(x+2)%5 + 5*y]);
            end
        end
        rc_lane = '0;
        for (int j = 0; j <= l; j++) rc_lane[(1 << j) - 1] = rc_i[j];
        ch[0] = ch[0] ^ rc_lane;
        for (int k = 0; k < 25; k++) state_o[w*k +: w] = ch[k];
    end

endmodule

// File: rtl/keccak_squeeze.sv
// Sponge squeeze controller: streams rate lanes, re-permuting between blocks.
// Define KECCAK_SQUEEZE_2ROUND_EN to run two chained rounds per permute cycle.
module keccak_squeeze import keccak_pkg::*; #(
    parameter int unsigned l          = 6,
    parameter int unsigned w          = 2**l,
    parameter int unsigned b          = 25*w,
    parameter int unsigned RATE_LANES = 21
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [b-1:0] load_state,
    input  logic [15:0]  out_len,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [w-1:0] out_data,
    output logic         out_last
);

    localparam int unsigned NR = nr(l);
`ifdef KECCAK_SQUEEZE_2ROUND_EN
    localparam int unsigned RoundsPerCycle = 2;
`else
    localparam int unsigned RoundsPerCycle = 1;
`endif
    localparam int unsigned NumCycles = NR / RoundsPerCycle;
    localparam logic [4:0] LastIdx   = 5'(RATE_LANES - 1);
    localparam logic [4:0] LastRound = 5'(NumCycles - 1);

    squeeze_state_e state_q, state_d;
    logic [b-1:0]   st_q, st_d;
    logic [15:0]    rem_q, rem_d;
    logic [4:0]     idx_q, idx_d;
    logic [4:0]     round_q, round_d;
    logic [b-1:0]   perm_out;
    logic [b-1:0]   r0_out;
    logic [w-1:0]   lanes [25];
    logic           emit;

`ifdef KECCAK_SQUEEZE_2ROUND_EN
    logic [4:0] rc_idx0, rc_idx1;
    assign rc_idx0 = {round_q[3:0], 1'b0};
    assign rc_idx1 = {round_q[3:0], 1'b1};

    keccak_round #(.l(l), .w(w)) u_round0 (
        .state_i (st_q),
        .rc_i    (RC[rc_idx0][l:0]),
        .state_o (r0_out)
    );

    keccak_round #(.l(l), .w(w)) u_round1 (
        .state_i (r0_out),
        .rc_i    (RC[rc_idx1][l:0]),
        .state_o (perm_out)
    );
`else
    keccak_round #(.l(l), .w(w)) u_round0 (
        .state_i (st_q),
        .rc_i    (RC[round_q][l:0]),
        .state_o (r0_out)
    );

    assign perm_out = r0_out;
`endif

    always_comb begin
        for (int k = 0; k < 25; k++) lanes[k] = st_q[w*k +: w];
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        round_d = round_q;
        unique case (state_q)
            StIdle: begin
                // A zero-length request is accepted but leaves the block idle.
                if (load_valid && out_len != 16'd0) begin
                    st_d    = load_state;
                    rem_d   = out_len;
                    idx_d   = 5'd0;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    rem_d = rem_q - 16'd1;
                    idx_d = idx_q + 5'd1;
                    if (rem_q == 16'd1) begin
                        state_d = StIdle;
                    end else if (idx_q == LastIdx) begin
                        state_d = StPermute;
                        round_d = 5'd0;
                    end
                end
            end
            StPermute: begin
                st_d    = perm_out;
                round_d = round_q + 5'd1;
                if (round_q == LastRound) begin
                    state_d = StEmit;
                    idx_d   = 5'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            st_q    <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            round_q <= round_d;
        end
    end

    assign emit       = (state_q == StEmit) && !reset;
    assign load_ready = (state_q == StIdle) && !reset;
    assign out_valid  = emit;
    assign out_last   = emit && (rem_q == 16'd1);
    assign out_data   = emit ? lanes[idx_q] : '0;

endmodule

// File: tb/tb_keccak_squeeze.sv
// Self-checking bench for keccak_squeeze against an independent Keccak-f[1600] sponge model.
module tb_keccak_squeeze;

    localparam int B    = 1600;
    localparam int W    = 64;
    localparam int RATE = 21;
`ifdef KECCAK_SQUEEZE_2ROUND_EN
    localparam int GAP = 12;
`else
    localparam int GAP = 24;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [B-1:0]  load_state;
    logic [15:0]   out_len;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keccak_squeeze #(.l(6), .w(64), .b(1600), .RATE_LANES(RATE)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_state (load_state),
        .out_len    (out_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    // Reference model: state as A[x][y], constants derived from the LFSR and rho walk.
    logic [63:0] ms [5][5];
    int          rho_off [5][5];
    logic [63:0] rc_full [24];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rotl64(input logic [63:0] v, input int n);
        if (n == 0) return v;
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic bit lfsr_rc(input int t);
        logic [8:0] r;
        r = 9'h1;
        for (int i = 1; i <= t % 255; i++) begin
            r = {r[7:0], 1'b0};
            r[0] = r[0] ^ r[8];
            r[4] = r[4] ^ r[8];
            r[5] = r[5] ^ r[8];
            r[6] = r[6] ^ r[8];
            r[8] = 1'b0;
        end
        return r[0];
    endfunction

    task automatic model_init;
        int x, y, nx;
        rho_off[0][0] = 0;
        x = 1;
        y = 0;
        for (int t = 0; t < 24; t++) begin
            rho_off[x][y] = ((t + 1) * (t + 2) / 2) % 64;
            nx = y;
            y  = (2 * x + 3 * y) % 5;
            x  = nx;
        end
        for (int r = 0; r < 24; r++) begin
            rc_full[r] = '0;
            for (int j = 0; j < 7; j++) rc_full[r][(1 << j) - 1] = lfsr_rc(j + 7 * r);
        end
    endtask

    task automatic model_permute;
        logic [63:0] c [5];
        logic [63:0] bt [5][5];
        for (int r = 0; r < 24; r++) begin
            for (int x = 0; x < 5; x++) c[x] = ms[x][0] ^ ms[x][1] ^ ms[x][2] ^ ms[x][3] ^ ms[x][4];
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    ms[x][y] ^= c[(x + 4) % 5] ^ rotl64(c[(x + 1) % 5], 1);
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    bt[y][(2 * x + 3 * y) % 5] = rotl64(ms[x][y], rho_off[x][y]);
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    ms[x][y] = bt[x][y] ^ (~bt[(x + 1) % 5][y] & bt[(x + 2) % 5][y]);
            ms[0][0] ^= rc_full[r];
        end
    endtask

    task automatic do_load(input logic [B-1:0] st, input int len, output bit ok);
        int n;
        n = 0;
        while (!load_ready && n < 100) begin
            step;
            n++;
        end
        ok = load_ready;
        if (!ok) begin
            chk("load_ready wait", 64'(load_ready), 64'd1);
            return;
        end
        load_valid = 1'b1;
        load_state = st;
        out_len    = 16'(len);
        step;
        load_valid = 1'b0;
    endtask

    // mode: 0 ready always, 1 ready toggling, 2 ready random with junk loads while busy
    task automatic run_squeeze(input logic [B-1:0] st, input int len, input int mode,
                               input string tag, output logic [63:0] last_word);
        int n, idx_m, cyc, invalid, budget;
        bit have_exp, ok, rdy;
        logic [63:0] exp_w;
        last_word = '0;
        do_load(st, len, ok);
        if (!ok) return;
        for (int k = 0; k < 25; k++) ms[k % 5][k / 5] = st[64 * k +: 64];
        n        = 0;
        idx_m    = 0;
        cyc      = 0;
        invalid  = 0;
        have_exp = 0;
        exp_w    = '0;
        budget   = 4 * len + 2 * GAP * (len / RATE + 1) + 20;
        while (n < len && cyc < budget) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            out_ready = rdy;
            if (mode == 2) begin
                load_valid = 1'($urandom_range(0, 1));
                load_state = {50{$urandom()}};
                out_len    = 16'($urandom_range(1, 9));
            end
            if (out_valid) begin
                if (!have_exp) begin
                    if (idx_m == RATE) begin
                        model_permute();
                        idx_m = 0;
                    end
                    exp_w    = ms[idx_m % 5][idx_m / 5];
                    have_exp = 1;
                end
                chk({tag, " data"}, out_data, exp_w);
                chk({tag, " last"}, 64'(out_last), 64'(n == len - 1));
                if (rdy) begin
                    last_word = out_data;
                    have_exp  = 0;
                    idx_m++;
                    n++;
                end
            end else begin
                invalid++;
            end
            step;
            cyc++;
        end
        load_valid = 1'b0;
        out_ready  = 1'b0;
        if (n < len) chk({tag, " timeout words"}, 64'(n), 64'(len));
        chk({tag, " permute gap"}, 64'(invalid), 64'(((len - 1) / RATE) * GAP));
        chk({tag, " ready after"}, 64'(load_ready), 64'd1);
        chk({tag, " idle valid"}, 64'(out_valid), 64'd0);
    endtask

    typedef struct {
        int          kind;      // 0 zero state, 1 lane k = k, 2 random
        int          len;
        int          mode;
        bit          chk_last;
        logic [63:0] exp_last;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [B-1:0] st;
        logic [63:0]  lw;
        bit           ok;
        int           hs;

        vecs[0] = '{0, 3, 0, 1, 64'h0};
        vecs[1] = '{0, 22, 0, 1, 64'hF1258F7940E1DDE7};
        vecs[2] = '{1, 5, 1, 1, 64'd4};
        vecs[3] = '{2, 1, 2, 0, 64'h0};
        vecs[4] = '{2, 21, 2, 0, 64'h0};
        vecs[5] = '{2, $urandom_range(23, 42), 0, 0, 64'h0};
        vecs[6] = '{2, $urandom_range(43, 70), 2, 0, 64'h0};
        vecs[7] = '{1, 44, 1, 0, 64'h0};

        model_init();
        reset      = 1'b1;
        load_valid = 1'b0;
        load_state = '0;
        out_len    = '0;
        out_ready  = 1'b0;
        step;
        step;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_last", 64'(out_last), 64'd0);
        chk("reset out_data", out_data, 64'd0);
        chk("reset load_ready", 64'(load_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("post-reset load_ready", 64'(load_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            st = '0;
            if (vecs[i].kind == 1) for (int k = 0; k < 25; k++) st[64 * k +: 64] = 64'(k);
            if (vecs[i].kind == 2) for (int k = 0; k < 50; k++) st[32 * k +: 32] = $urandom();
            run_squeeze(st, vecs[i].len, vecs[i].mode, $sformatf("vec%0d", i), lw);
            if (vecs[i].chk_last) chk($sformatf("vec%0d final word", i), lw, vecs[i].exp_last);
        end

        // Zero-length request is swallowed.
        do_load('1, 0, ok);
        for (int i = 0; i < 4; i++) begin
            chk("len0 out_valid", 64'(out_valid), 64'd0);
            chk("len0 load_ready", 64'(load_ready), 64'd1);
            step;
        end

        // Reset while permuting aborts the request.
        do_load('0, 30, ok);
        out_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 100 && hs < RATE; c++) begin
            if (out_valid) hs++;
            step;
        end
        out_ready = 1'b0;
        chk("abort handshakes", 64'(hs), 64'(RATE));
        step;
        step;
        chk("abort in permute", 64'(out_valid), 64'd0);
        reset = 1'b1;
        step;
        reset = 1'b0;
        #1;
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort load_ready", 64'(load_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) chk("abort no words", 64'(out_valid), 64'd0);
            step;
        end
        run_squeeze('0, 3, 0, "after abort", lw);
        chk("after abort final word", lw, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keccak_squeeze.md
KECCAK_SQUEEZE -- requirements
Module: keccak_squeeze

Interface
REQ-001 SHALL have parameter l, default 6, meaning log2 of the lane width.
REQ-002 SHALL have parameter w, default 2**l, meaning lane width in bits.
REQ-003 SHALL have parameter b, default 25*w, meaning state width in bits.
REQ-004 SHALL have parameter RATE_LANES, default 21, meaning rate in lanes; legal range 1..24.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port load_valid  input  1  load_state and out_len are valid.
REQ-008 SHALL have port load_ready  output  1  block can accept a load.
REQ-009 SHALL have port load_state  input  b  sponge state; lane (i,j) at bits w*(i+5*j) +: w.
REQ-010 SHALL have port out_len  input  16  number of w-bit output words requested.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the word.
REQ-013 SHALL have port out_data  output  w  current output lane.
REQ-014 SHALL have port out_last  output  1  current word is the final requested word.

Function
REQ-015 SHALL implement states IDLE, EMIT and PERMUTE.
REQ-016 SHALL drive load_ready=1 only in IDLE; a load handshake is load_valid && load_ready.
REQ-017 On a load with out_len>0, SHALL capture load_state, set remaining=out_len and lane index=0, and enter EMIT; out_valid rises on the next cycle.
REQ-018 On a load with out_len=0, SHALL accept the load, emit nothing, and remain in IDLE.
REQ-019 In EMIT, SHALL hold out_valid=1 with out_data = lane index of the held state, in order 0,1,2,... (flat index i+5*j).
REQ-020 SHALL keep out_data and out_last stable while out_valid && !out_ready.
REQ-021 SHALL assert out_last exactly when remaining==1 in EMIT.
REQ-022 On an output handshake, SHALL decrement remaining and increment the lane index.
REQ-023 After the handshake that takes remaining to 0, SHALL enter IDLE; load_ready is 1 the next cycle.
REQ-024 Otherwise, after the handshake that takes the lane index to RATE_LANES, SHALL enter PERMUTE with the round counter at 0.
REQ-025 PERMUTE SHALL apply one Keccak-p round per cycle, round r using constant RC[r], for NR=12+2*l cycles.
REQ-026 After the final round, SHALL enter EMIT with lane index 0; out_valid=0 throughout PERMUTE.
REQ-027 SHALL ignore out_ready outside EMIT and load_valid outside IDLE.

Reset
REQ-028 While reset is high, SHALL set state=IDLE, out_valid=0, out_last=0, out_data=0, load_ready=0, and clear the counters and held state.
REQ-029 Reset mid-EMIT or mid-PERMUTE SHALL abort the operation with no further words; load_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-030 With KECCAK_SQUEEZE_2ROUND_EN defined, PERMUTE SHALL apply two chained rounds per cycle (RC[2k], RC[2k+1]) and last NR/2 cycles.
REQ-031 Without KECCAK_SQUEEZE_2ROUND_EN, SHALL apply one round per cycle; the output word sequence is identical in both builds.

Structure
REQ-032 SHALL place the NR function, the per-round (l+1)-bit iota constant table RC, and the state enum in shared package keccak_pkg.
REQ-033 SHALL instantiate the existing keccak_round sub-module for the permutation (two chained instances under the macro) and no other sub-modules.

Verification
REQ-034 Load all-zero state, out_len=3, out_ready=1 -> three words of 0; out_last on the third word; load_ready=1 on the following cycle.
REQ-035 Load all-zero state, out_len=22, RATE_LANES=21 -> 21 zero words, then 24 cycles with out_valid=0 (12 with the macro), then 0xF1258F7940E1DDE7 with out_last=1.
REQ-036 Load state with lane k = k for k in 0..24, out_len=5, out_ready toggling 1/0 -> words 0,1,2,3,4 in order, each held stable while stalled.
REQ-037 Load with out_len=0 -> out_valid never rises and load_ready stays 1.
REQ-038 Assert reset for 1 cycle during PERMUTE -> out_valid=0 and load_ready=1 on the next cycle; a new load then behaves as in REQ-034.
